// File: rtl/digit_counter_mux_pkg.sv
// Shared constants, the BCD state record and the single-digit-pair step helper
// for the two-digit multiplexed counter.
package digit_counter_mux_pkg;

  localparam logic [1:0] SEL_ONES   = 2'b01;
  localparam logic [1:0] SEL_TENS   = 2'b10;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef struct packed {
    logic [3:0] ones;
    logic [3:0] tens;
    logic       wrap;
  } bcd_state_t;

  // One count step of the two-digit BCD value. Out-of-range digits are
  // clamped to 9 first so a corrupted register recovers on the next step.
  function automatic bcd_state_t bcd_step(input logic [3:0] ones_in,
                                          input logic [3:0] tens_in,
                                          input logic       up_in);
    bcd_state_t r;
    logic [3:0] o;
    logic [3:0] t;
    o = (ones_in > BCD_MAX) ? BCD_MAX : ones_in;
    t = (tens_in > BCD_MAX) ? BCD_MAX : tens_in;
    r.ones = o;
    r.tens = t;
    r.wrap = 1'b0;
    if (up_in) begin
      if (o == BCD_MAX) begin
        r.ones = 4'd0;
        if (t == BCD_MAX) begin
          r.tens = 4'd0;
          r.wrap = 1'b1;
        end else begin
          r.tens = t + 4'd1;
        end
      end else begin
        r.ones = o + 4'd1;
      end
    end else begin
      if (o == 4'd0) begin
        r.ones = BCD_MAX;
        if (t == 4'd0) begin
          r.tens = BCD_MAX;
          r.wrap = 1'b1;
        end else begin
          r.tens = t - 4'd1;
        end
      end else begin
        r.ones = o - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_counter_mux_tick_gen.sv
// Parameterised clock divider: counts 0..DIV-1 while enabled and emits a
// single-cycle tick on the terminal value. Holds its value while disabled.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int              W    = $clog2(DIV);
  localparam logic [W-1:0]    LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Tick only fires on an enabled cycle so a frozen divider never steps.
  assign tick = en && (cnt == LAST);

  // Divider counter: clear wins, then advance or wrap while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_counter_mux.sv
// Two-digit BCD up/down counter with a prescaled count tick and a
// time-multiplexed digit output for a 7-segment decoder.
module digit_counter_mux
  import digit_counter_mux_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int MUX_DIV  = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clear,
  output logic [3:0] counter,
  output logic [1:0] digit_sel,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       wrap
);

  logic       count_tick;
  logic       scan_tick;
  bcd_state_t step_res;
  logic [1:0] sel_next;
  logic [3:0] counter_next;

  tick_gen #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clear (clear),
    .tick  (count_tick)
  );

  tick_gen #(.DIV(MUX_DIV)) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clear (1'b0),
    .tick  (scan_tick)
  );

  // Next BCD value for the current direction.
  always_comb begin
    step_res = bcd_step(ones, tens, up);
  end

  // Count registers: clear beats tick; wrap lives for one cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= 4'd0;
      tens <= 4'd0;
      wrap <= 1'b0;
    end else if (clear) begin
      ones <= 4'd0;
      tens <= 4'd0;
      wrap <= 1'b0;
    end else if (count_tick) begin
      ones <= step_res.ones;
      tens <= step_res.tens;
      wrap <= step_res.wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

  // Digit select and the code shown for it, from the pre-edge digit values.
  always_comb begin
    sel_next = digit_sel;
    if (scan_tick) begin
      sel_next = (digit_sel == SEL_ONES) ? SEL_TENS : SEL_ONES;
    end
    counter_next = ones;
    if (sel_next == SEL_TENS) begin
      counter_next = (BLANK_LZ && (tens == 4'd0)) ? BLANK_CODE : tens;
    end
  end

  // Select and digit code are registered together so they change on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel <= SEL_ONES;
      counter   <= 4'h0;
    end else begin
      digit_sel <= sel_next;
      counter   <= counter_next;
    end
  end

endmodule

// File: tb/tb_digit_counter_mux.sv
// Directed plus randomized bench for digit_counter_mux with a value-level
// reference model (count held as an integer 0..99).
module tb_digit_counter_mux;

  localparam int TD = 4;
  localparam int MD = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  logic up    = 1'b1;
  logic clear = 1'b0;

  logic [3:0] counter_a, ones_a, tens_a, counter_b, ones_b, tens_b;
  logic [1:0] sel_a, sel_b;
  logic       wrap_a, wrap_b;

  always #5 clk = ~clk;

  digit_counter_mux #(.TICK_DIV(TD), .MUX_DIV(MD), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear),
    .counter(counter_a), .digit_sel(sel_a), .ones(ones_a), .tens(tens_a), .wrap(wrap_a)
  );

  digit_counter_mux #(.TICK_DIV(TD), .MUX_DIV(MD), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear),
    .counter(counter_b), .digit_sel(sel_b), .ones(ones_b), .tens(tens_b), .wrap(wrap_b)
  );

  // Reference model state
  int         m_val;
  int         m_pre;
  int         m_scan;
  bit         m_tens_sel;
  logic [3:0] m_cnt_a;
  logic [3:0] m_cnt_b;
  bit         m_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [3:0] shown(bit tens_sel, int val, bit blank);
    if (tens_sel) begin
      if (blank && (val / 10 == 0)) return 4'hF;
      return 4'(val / 10);
    end
    return 4'(val % 10);
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_scan = 0; m_tens_sel = 1'b0;
    m_cnt_a = 4'h0; m_cnt_b = 4'h0; m_wrap = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs as they are now.
  task automatic model_edge();
    bit tick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = en && (m_pre == TD - 1);
    if (m_scan == MD - 1) m_tens_sel = !m_tens_sel;
    m_cnt_a = shown(m_tens_sel, m_val, 1'b1);
    m_cnt_b = shown(m_tens_sel, m_val, 1'b0);
    m_scan  = (m_scan + 1) % MD;
    if (clear) begin
      m_val = 0; m_pre = 0; m_wrap = 1'b0;
    end else begin
      if (en) m_pre = (m_pre + 1) % TD;
      if (tick) begin
        if (up) begin
          m_wrap = (m_val == 99);
          m_val  = (m_val + 1) % 100;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 99) % 100;
        end
      end else begin
        m_wrap = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [1:0] es;
    es = m_tens_sel ? 2'b10 : 2'b01;
    chk({ctx, ".ones"},    ones_a,            4'(m_val % 10));
    chk({ctx, ".tens"},    tens_a,            4'(m_val / 10));
    chk({ctx, ".sel"},     {2'b00, sel_a},    {2'b00, es});
    chk({ctx, ".wrap"},    {3'b000, wrap_a},  {3'b000, m_wrap});
    chk({ctx, ".cnt_blk"}, counter_a,         m_cnt_a);
    chk({ctx, ".cnt_nbl"}, counter_b,         m_cnt_b);
  endtask

  task automatic step(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic run_to_val(input int target, input string ctx);
    for (int i = 0; i < 1000 && m_val != target; i++) step(ctx);
  endtask

  task automatic async_reset(input string ctx);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all(ctx);
    step(ctx);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset: asynchronous, observed before any clock edge.
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("por");
    step("por_hold");
    rst_n = 1'b1;

    // Count up for 40 cycles: exactly 10 ticks reach 10.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 40; i++) step("up40");
    chk("up40.final_ones", ones_a, 4'd0);
    chk("up40.final_tens", tens_a, 4'd1);

    // Asynchronous reset mid-count.
    for (int i = 0; i < 6; i++) step("pre_rst");
    async_reset("mid_rst");

    // Up to 99, one more tick wraps to 00; then down wraps back to 99.
    run_to_val(99, "to99");
    for (int i = 0; i < 8 && !m_wrap; i++) step("wrap_up");
    chk("wrap_up.pulse", {3'b000, wrap_a}, 4'h1);
    step("wrap_up_after");
    chk("wrap_up.one_cycle", {3'b000, wrap_a}, 4'h0);
    up = 1'b0;
    for (int i = 0; i < 8 && !m_wrap; i++) step("wrap_dn");
    chk("wrap_dn.ones", ones_a, 4'd9);
    chk("wrap_dn.tens", tens_a, 4'd9);

    // Freeze with en low while the prescaler sits at 2.
    up = 1'b1;
    for (int i = 0; i < 8 && m_pre != 2; i++) step("to_pre2");
    en = 1'b0;
    for (int i = 0; i < 7; i++) step("frozen");
    en = 1'b1;
    for (int i = 0; i < 3; i++) step("resume");

    // Clear coinciding with a tick at 37.
    run_to_val(37, "to37");
    for (int i = 0; i < 8 && m_pre != TD - 1; i++) step("pre_tick37");
    clear = 1'b1;
    step("clear_tick");
    chk("clear_tick.wrap", {3'b000, wrap_a}, 4'h0);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) step("post_clear");
    chk("post_clear.ones_hold", ones_a, 4'd0);
    step("post_clear_tick");
    chk("post_clear.ones_step", ones_a, 4'd1);

    // Leading-zero blanking at 05 with count frozen.
    run_to_val(5, "to05");
    en = 1'b0;
    for (int i = 0; i < 12; i++) step("blank05");

    // Randomised traffic with an occasional mid-run reset.
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      up    = $urandom_range(0, 1) != 0;
      clear = ($urandom_range(0, 40) == 0);
      if (i == 200) async_reset("rand_rst");
      else step("rand");
    end
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
